arb_requester: RTL and testbench

ARB_REQUESTER -- requirements
Module: arb_requester

---
 rtl/arb_req_pkg.sv | 16 +
 rtl/arb_req_timer.sv | 29 ++
 rtl/arb_requester.sv | 124 ++++++++++++
 tb/tb_arb_requester.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_req_pkg.sv
// Shared definitions for the arbitrated burst requester: state encoding,
// parameter defaults and counter width.
package arb_req_pkg;

  localparam int unsigned DATA_W_DEF  = 8;
  localparam int unsigned TIMEOUT_DEF = 64;
  localparam int unsigned CNT_W       = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_XFER    = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

endpackage

// File: rtl/arb_req_timer.sv
// Grant wait counter: cleared on job accept, counts while enabled,
// flags expiry when the count reaches TIMEOUT-1.
module arb_req_timer
  import arb_req_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expire = (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/arb_requester.sv
// Burst requester: takes a job, requests the shared bus from an arbiter,
// streams job_len+1 client beats onto the bus while granted, then releases.
module arb_requester
  import arb_req_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              job_valid,
  input  logic [3:0]        job_len,
  output logic              job_ready,
  output logic              req,
  input  logic              gnt,
  input  logic [DATA_W-1:0] src_data,
  input  logic              src_valid,
  output logic              src_ready,
  output logic [DATA_W-1:0] bus_data,
  output logic              bus_valid,
  output logic              done,
  output logic              timeout_err,
  output logic              busy
);

  state_t           state_q, state_d;
  logic             req_d, done_d, terr_d;
  logic [3:0]       len_q, len_d;
  logic [CNT_W-1:0] beat_q, beat_d;
  logic             tmr_clear, tmr_en, tmr_expire;
  logic             beat_fire;

  arb_req_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (tmr_clear),
    .enable  (tmr_en),
    .expire  (tmr_expire)
  );

  assign job_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign src_ready = (state_q == ST_XFER) && gnt;
  assign beat_fire = src_valid && src_ready;

  always_comb begin
    state_d   = state_q;
    req_d     = req;
    done_d    = 1'b0;
    terr_d    = 1'b0;
    len_d     = len_q;
    beat_d    = beat_q;
    tmr_clear = 1'b0;
    tmr_en    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (job_valid) begin
          len_d     = job_len;
          beat_d    = '0;
          req_d     = 1'b1;
          tmr_clear = 1'b1;
          state_d   = ST_REQ;
        end
      end
      ST_REQ: begin
        // A grant arriving on the expiry cycle wins over the timeout
        if (gnt) begin
          state_d = ST_XFER;
        end else if (tmr_expire) begin
          req_d   = 1'b0;
          terr_d  = 1'b1;
          state_d = ST_RELEASE;
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_XFER: begin
        if (beat_fire) begin
          beat_d = beat_q + CNT_W'(1);
          if (beat_q == CNT_W'(len_q)) begin
            req_d   = 1'b0;
            done_d  = 1'b1;
            state_d = ST_RELEASE;
          end
        end
      end
      ST_RELEASE: begin
        req_d = 1'b0;
        if (!gnt) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      req         <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      len_q       <= '0;
      beat_q      <= '0;
      bus_valid   <= 1'b0;
      bus_data    <= '0;
    end else begin
      state_q     <= state_d;
      req         <= req_d;
      done        <= done_d;
      timeout_err <= terr_d;
      len_q       <= len_d;
      beat_q      <= beat_d;
      bus_valid   <= beat_fire;
      if (beat_fire) begin
        bus_data <= src_data;
      end
    end
  end

endmodule

// File: tb/tb_arb_requester.sv
// Scoreboard bench for arb_requester: the driver acts as arbiter and client,
// predicts bus beats and done/timeout pulses; a monitor compares them.
module tb_arb_requester;

  localparam int DW = 8;
  localparam int TO = 64;

  logic          clock, reset_n;
  logic          job_valid, job_ready, req, gnt, src_valid, src_ready;
  logic [3:0]    job_len;
  logic [DW-1:0] src_data, bus_data;
  logic          bus_valid, done, timeout_err, busy;

  arb_requester #(.DATA_W(DW), .TIMEOUT(TO)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .job_valid   (job_valid),
    .job_len     (job_len),
    .job_ready   (job_ready),
    .req         (req),
    .gnt         (gnt),
    .src_data    (src_data),
    .src_valid   (src_valid),
    .src_ready   (src_ready),
    .bus_data    (bus_data),
    .bus_valid   (bus_valid),
    .done        (done),
    .timeout_err (timeout_err),
    .busy        (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int passes = 0;
  int cyc    = 0;

  always @(posedge clock) cyc <= cyc + 1;

  typedef struct { logic [DW-1:0] data; int cyc; } beat_t;
  typedef struct { int kind; int cyc; } evt_t;   // kind 1 = done, 2 = timeout

  beat_t exp_beats[$];
  evt_t  exp_evts[$];

  task automatic check_b(input string name, input logic act, input logic exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic check_i(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: compares every presented output against the predicted queues
  always @(negedge clock) begin
    beat_t b;
    evt_t  e;
    while (exp_beats.size() > 0 && exp_beats[0].cyc < cyc) begin
      b = exp_beats.pop_front();
      check_i("bus_beat_missing", cyc, b.cyc);
    end
    while (exp_evts.size() > 0 && exp_evts[0].cyc < cyc) begin
      e = exp_evts.pop_front();
      check_i("event_missing", cyc, e.cyc);
    end
    if (bus_valid) begin
      if (exp_beats.size() == 0) check_b("bus_valid_unexpected", bus_valid, 1'b0);
      else begin
        b = exp_beats.pop_front();
        check_i("bus_data", int'(bus_data), int'(b.data));
        check_i("bus_valid_cycle", cyc, b.cyc);
      end
    end
    if (done) begin
      check_b("done_with_last_beat", bus_valid, 1'b1);
      if (exp_evts.size() == 0) check_b("done_unexpected", done, 1'b0);
      else begin
        e = exp_evts.pop_front();
        check_i("done_kind", 1, e.kind);
        check_i("done_cycle", cyc, e.cyc);
      end
    end
    if (timeout_err) begin
      if (exp_evts.size() == 0) check_b("timeout_unexpected", timeout_err, 1'b0);
      else begin
        e = exp_evts.pop_front();
        check_i("timeout_kind", 2, e.kind);
        check_i("timeout_cycle", cyc, e.cyc);
      end
    end
  end

  // One job: len = beats-1, grant after d cycles of request (d >= TO never grants),
  // hold = extra grant cycles after the burst, mode 0 full rate / 1 random / 2 stall 3 cycles,
  // rst2 = pulse reset after the second beat.
  task automatic run_job(input int len, input int d, input int hold, input int mode,
                         input bit rnd_data, input logic [7:0] base, input bit rst2);
    logic [7:0] data [16];
    bit    granted = 1'b0;
    int    b = 0;
    int    c = 0;
    beat_t bt;
    evt_t  ev;
    for (int i = 0; i < 16; i++) data[i] = rnd_data ? 8'($urandom) : base + 8'(i);

    check_b("job_ready_idle", job_ready, 1'b1);
    check_b("busy_idle", busy, 1'b0);
    job_valid = 1'b1;
    job_len   = 4'(len);
    @(negedge clock);

    for (int k = 0; k < TO && !granted; k++) begin
      check_b("req_wait", req, 1'b1);
      check_b("busy_wait", busy, 1'b1);
      check_b("job_ready_wait", job_ready, 1'b0);
      job_valid = 1'($urandom_range(0, 1));
      job_len   = 4'($urandom);
      src_valid = 1'($urandom_range(0, 1));
      src_data  = 8'($urandom);
      gnt       = (k >= d);
      #1 check_b("src_ready_wait", src_ready, 1'b0);
      if (gnt) granted = 1'b1;
      else if (k == TO - 1) begin
        ev.kind = 2; ev.cyc = cyc + 1; exp_evts.push_back(ev);
      end
      @(negedge clock);
    end

    if (!granted) begin
      check_b("req_after_timeout", req, 1'b0);
      check_b("busy_after_timeout", busy, 1'b1);
      gnt       = 1'b0;
      job_valid = 1'($urandom_range(0, 1));
      @(negedge clock);
      job_valid = 1'b0;
      return;
    end

    while (b <= len) begin
      check_b("req_xfer", req, 1'b1);
      check_b("busy_xfer", busy, 1'b1);
      case (mode)
        0: begin gnt = 1'b1; src_valid = 1'b1; end
        1: begin
          gnt       = (c > 40) || ($urandom_range(0, 3) != 0);
          src_valid = (c > 40) || ($urandom_range(0, 3) != 0);
        end
        default: begin gnt = !(c >= 3 && c <= 5); src_valid = 1'b1; end
      endcase
      src_data  = data[b];
      job_valid = 1'($urandom_range(0, 1));
      #1 check_b("src_ready_xfer", src_ready, gnt);
      check_b("job_ready_xfer", job_ready, 1'b0);
      if (gnt && src_valid) begin
        bt.data = data[b]; bt.cyc = cyc + 1; exp_beats.push_back(bt);
        b++;
        if (b == len + 1) begin
          ev.kind = 1; ev.cyc = cyc + 1; exp_evts.push_back(ev);
        end
      end
      c++;
      @(negedge clock);
      if (rst2 && b == 2) begin
        src_valid = 1'b0;
        gnt       = 1'b0;
        job_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check_b("rst_req", req, 1'b0);
        check_b("rst_bus_valid", bus_valid, 1'b0);
        check_i("rst_bus_data", int'(bus_data), 0);
        check_b("rst_busy", busy, 1'b0);
        check_b("rst_src_ready", src_ready, 1'b0);
        check_b("rst_done", done, 1'b0);
        @(negedge clock);
        reset_n = 1'b1;
        return;
      end
    end

    for (int h = 0; h <= hold; h++) begin
      check_b("req_release", req, 1'b0);
      check_b("busy_release", busy, 1'b1);
      check_b("job_ready_release", job_ready, 1'b0);
      gnt       = (h < hold);
      src_valid = 1'($urandom_range(0, 1));
      job_valid = 1'($urandom_range(0, 1));
      #1 check_b("src_ready_release", src_ready, 1'b0);
      @(negedge clock);
    end
    job_valid = 1'b0;
    src_valid = 1'b0;
  endtask

  initial begin
    int sel, d;
    reset_n   = 1'b0;
    job_valid = 1'b0;
    job_len   = '0;
    gnt       = 1'b0;
    src_valid = 1'b0;
    src_data  = '0;
    #1;
    check_b("reset_req", req, 1'b0);
    check_b("reset_bus_valid", bus_valid, 1'b0);
    check_i("reset_bus_data", int'(bus_data), 0);
    check_b("reset_done", done, 1'b0);
    check_b("reset_timeout_err", timeout_err, 1'b0);
    check_b("reset_busy", busy, 1'b0);
    check_b("reset_src_ready", src_ready, 1'b0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    run_job(3, 2, 0, 0, 1'b0, 8'hA0, 1'b0);
    run_job(0, TO, 0, 0, 1'b1, 8'h00, 1'b0);
    run_job(1, TO - 1, 0, 0, 1'b1, 8'h00, 1'b0);
    run_job(0, 1, 2, 0, 1'b0, 8'h5C, 1'b0);
    run_job(7, 0, 0, 0, 1'b0, 8'h30, 1'b1);
    run_job(5, 1, 1, 0, 1'b1, 8'h00, 1'b0);
    run_job(9, 0, 0, 2, 1'b1, 8'h00, 1'b0);
    run_job(15, 3, 0, 0, 1'b1, 8'h00, 1'b0);

    for (int j = 0; j < 40; j++) begin
      sel = int'($urandom_range(0, 9));
      d   = (sel < 6) ? sel : (sel == 6) ? TO - 2 : (sel == 7) ? TO - 1 : TO + 2;
      run_job(int'($urandom_range(0, 15)), d, int'($urandom_range(0, 2)), 1, 1'b1, 8'h00, 1'b0);
      repeat (int'($urandom_range(0, 2))) @(negedge clock);
    end

    repeat (3) @(negedge clock);
    check_i("beats_outstanding", exp_beats.size(), 0);
    check_i("events_outstanding", exp_evts.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
